// File: rtl/dtree_feature_sequencer.sv
// Feature sequencer for a combinational decision tree: loads six feature bytes,
// lets the tree settle for SETTLE_CYCLES edges, then holds the class until the consumer takes it.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_LOAD   | accepting feature bytes into X0..X5, in_ready high
//   ST_SETTLE | features frozen, down-counting until the tree output is stable
//   ST_HOLD   | res_class captured, res_valid high until res_ready
module dtree_feature_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] X0,
    output logic [7:0] X1,
    output logic [7:0] X2,
    output logic [7:0] X3,
    output logic [7:0] X4,
    output logic [7:0] X5,
    input  logic [1:0] cls_in,
    output logic [1:0] res_class,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] frame_cnt,
    output logic       sof_err
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Terminal count is zero, so loading N-1 yields exactly N edges in SETTLE.
    localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_x [6];
    logic [1:0] r_res_class;
    logic       r_res_valid;
    logic [7:0] r_frame_cnt;
    logic       r_sof_err;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_cnt_done;
    logic       w_handshake;

    assign w_in_ready  = (r_state == ST_LOAD);
    assign w_accept    = in_valid & w_in_ready;
    assign w_cnt_done  = (r_cnt == 4'd0);
    assign w_handshake = r_res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_res_class <= 2'd0;
            r_res_valid <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_sof_err   <= 1'b0;
        end else begin
            r_sof_err <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        // A start-of-frame byte always resynchronises, even mid-frame.
                        if (in_sof) begin
                            r_idx     <= 3'd1;
                            r_sof_err <= (r_idx != 3'd0);
                        end else if (r_idx == 3'd5) begin
                            r_idx   <= 3'd0;
                            r_cnt   <= LP_CNT_LOAD;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_done) begin
                        r_res_class <= cls_in;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_res_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_idx       <= 3'd0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_x[i] <= 8'd0;
            end
        end else if (w_accept) begin
            if (in_sof) begin
                r_x[0] <= in_data;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (r_idx == 3'(i)) begin
                        r_x[i] <= in_data;
                    end
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign X0        = r_x[0];
    assign X1        = r_x[1];
    assign X2        = r_x[2];
    assign X3        = r_x[3];
    assign X4        = r_x[4];
    assign X5        = r_x[5];
    assign res_class = r_res_class;
    assign res_valid = r_res_valid;
    assign frame_cnt = r_frame_cnt;
    assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Randomised self-checking bench for dtree_feature_sequencer: a frame-level reference
// model (feature array, write index, result count) predicts every observed output.
module tb_dtree_feature_sequencer;

    localparam int S_A = 4;
    localparam int S_B = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_sof, in_ready;
    logic [7:0] X0, X1, X2, X3, X4, X5;
    logic [1:0] cls_in, res_class;
    logic       res_valid, res_ready, sof_err;
    logic [7:0] frame_cnt;

    logic [7:0] b_in_data;
    logic       b_in_valid, b_in_sof, b_in_ready;
    logic [7:0] b_x0, b_x1, b_x2, b_x3, b_x4, b_x5;
    logic [1:0] b_cls_in, b_res_class;
    logic       b_res_valid, b_res_ready, b_sof_err;
    logic [7:0] b_frame_cnt;

    dtree_feature_sequencer #(.SETTLE_CYCLES(S_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .X0(X0), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5),
        .cls_in(cls_in), .res_class(res_class), .res_valid(res_valid), .res_ready(res_ready),
        .frame_cnt(frame_cnt), .sof_err(sof_err)
    );

    dtree_feature_sequencer #(.SETTLE_CYCLES(S_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_sof(b_in_sof),
        .in_ready(b_in_ready), .X0(b_x0), .X1(b_x1), .X2(b_x2), .X3(b_x3), .X4(b_x4), .X5(b_x5),
        .cls_in(b_cls_in), .res_class(b_res_class), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .frame_cnt(b_frame_cnt), .sof_err(b_sof_err)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_x [6];
    assign dut_x[0] = X0;
    assign dut_x[1] = X1;
    assign dut_x[2] = X2;
    assign dut_x[3] = X3;
    assign dut_x[4] = X4;
    assign dut_x[5] = X5;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mx [6];
    int         midx;
    int         fcnt;
    logic [1:0] exp_cls;

    int mon_hs = 0;
    always @(posedge clk) if (res_valid && res_ready) mon_hs <= mon_hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_x();
        for (int i = 0; i < 6; i++) chk($sformatf("X%0d", i), dut_x[i], mx[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) mx[i] = 8'd0;
        midx = 0;
        fcnt = 0;
    endtask

    task automatic check_reset_outputs();
        check_x();
        chk("rst_res_class", res_class, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    // Reset asserted between edges; outputs must clear before any posedge arrives.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, output bit done);
        int n;
        bit err;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'($urandom);
        err  = 1'b0;
        done = 1'b0;
        if (sof) begin
            err   = (midx != 0);
            mx[0] = d;
            midx  = 1;
        end else begin
            mx[midx] = d;
            if (midx == 5) begin
                midx = 0;
                done = 1'b1;
            end else begin
                midx++;
            end
        end
        chk("sof_err", sof_err, err);
        check_x();
        chk("in_ready_after_byte", in_ready, !done);
    endtask

    // Called right after the sixth accept; the class seen at the S-th edge is the one captured.
    task automatic settle(input bit rnd);
        for (int k = 1; k <= S_A; k++) begin
            if (rnd) begin
                cls_in    = 2'($urandom);
                in_valid  = 1'($urandom);
                in_data   = 8'($urandom);
                in_sof    = 1'($urandom);
                res_ready = 1'($urandom);
            end
            chk("res_valid_early", res_valid, 0);
            chk("in_ready_settle", in_ready, 0);
            @(negedge clk);
        end
        exp_cls  = cls_in;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("res_valid_rise", res_valid, 1);
        chk("res_class", res_class, exp_cls);
        chk("in_ready_hold", in_ready, 0);
        check_x();
    endtask

    task automatic handshake(input int delay, input bit tied);
        if (!tied) res_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_sof   = 1'($urandom);
            cls_in   = 2'($urandom);
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_class", res_class, exp_cls);
            chk("hold_in_ready", in_ready, 0);
            check_x();
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        if (!tied) res_ready = 1'b0;
        fcnt = (fcnt + 1) % 256;
        chk("hs_res_valid_fall", res_valid, 0);
        chk("hs_frame_cnt", frame_cnt, fcnt);
        chk("hs_in_ready", in_ready, 1);
        check_x();
    endtask

    task automatic random_frame(input bit tied);
        bit done;
        logic s;
        done = 1'b0;
        while (!done) begin
            if (!tied) begin
                repeat ($urandom_range(0, 2)) begin
                    res_ready = 1'($urandom);
                    @(negedge clk);
                end
            end
            s = (midx == 0) ? 1'($urandom) : (($urandom % 8) == 0);
            send_byte(8'($urandom), s, done);
        end
        if (tied) cls_in = 2'($urandom);
        settle(!tied);
        handshake(tied ? 0 : $urandom_range(0, 5), tied);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int hs0;
        rst_n = 1'b0;
        in_data = 8'd0; in_valid = 1'b0; in_sof = 1'b0; cls_in = 2'd0; res_ready = 1'b0;
        b_in_data = 8'd0; b_in_valid = 1'b0; b_in_sof = 1'b0; b_cls_in = 2'd0; b_res_ready = 1'b0;
        model_reset();
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        chk("release_in_ready", in_ready, 1);

        // Directed frame 10..60, tree returns 2
        cls_in = 2'd2;
        for (int i = 0; i < 6; i++) send_byte(8'(10 * (i + 1)), i == 0, done);
        chk("directed_done", done, 1);
        settle(1'b0);
        chk("directed_class", res_class, 2);
        handshake(0, 1'b0);
        chk("directed_frame_cnt", frame_cnt, 1);

        // Consumer stalls 20 cycles while upstream keeps offering bytes
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 0, done);
        settle(1'b0);
        handshake(20, 1'b0);

        // Resync: three bytes then a fresh start-of-frame 0x55
        send_byte(8'h11, 1'b1, done);
        send_byte(8'h22, 1'b0, done);
        send_byte(8'h33, 1'b0, done);
        send_byte(8'h55, 1'b1, done);
        chk("resync_x0", X0, 8'h55);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, done);
        chk("resync_done", done, 1);
        cls_in = 2'd1;
        settle(1'b0);
        handshake(1, 1'b0);

        for (int f = 0; f < 30; f++) random_frame(1'b0);

        // 256 frames with consumer always ready: counter wraps back to zero
        do_reset();
        res_ready = 1'b1;
        @(negedge clk);
        hs0 = mon_hs;
        for (int f = 0; f < 256; f++) random_frame(1'b1);
        chk("wrap_frame_cnt", frame_cnt, 0);
        chk("wrap_result_count", mon_hs - hs0, 256);
        res_ready = 1'b0;

        // Reset in the middle of SETTLE drops the pending result
        for (int i = 0; i < 6; i++) send_byte(8'($urandom | 1), i == 0, done);
        @(negedge clk);
        do_reset();
        for (int k = 0; k < S_A + 3; k++) begin
            res_ready = 1'b1;
            chk("no_result_after_rst", res_valid, 0);
            chk("load_after_rst", in_ready, 1);
            @(negedge clk);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 0, done);
        cls_in = 2'd3;
        settle(1'b0);
        handshake(2, 1'b0);
        chk("after_rst_frame_cnt", frame_cnt, 1);

        // SETTLE_CYCLES=1: capture uses cls_in at the edge right after the sixth accept
        b_cls_in = 2'd0;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_sof   = (i == 0);
            b_in_data  = 8'(i + 100);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        b_in_sof   = 1'b0;
        chk("b_res_valid_early", b_res_valid, 0);
        chk("b_in_ready_settle", b_in_ready, 0);
        b_cls_in = 2'd2;
        @(negedge clk);
        chk("b_res_valid", b_res_valid, 1);
        chk("b_res_class", b_res_class, 2);
        chk("b_x5", b_x5, 105);
        b_cls_in = 2'd3;
        @(negedge clk);
        chk("b_res_class_stable", b_res_class, 2);
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready = 1'b0;
        chk("b_res_valid_fall", b_res_valid, 0);
        chk("b_frame_cnt", b_frame_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
